// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SHADOW   = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } hz_state_t;

  // RV32 canonical NOP (addi x0, x0, 0) loaded by a flushed stage register.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int WAIT_W          = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_trap;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(8'b1101_0110);
  localparam hz_ctrl_t CTRL_STALL  = hz_ctrl_t'(8'b0001_1110);
  localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(8'b1111_1110);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(8'b0000_0000);
  localparam hz_ctrl_t CTRL_TRAP   = hz_ctrl_t'(8'b0000_0001);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard request inputs and per-stage enable/flush strobes of the sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use_stall;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_trap;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output load_use_stall, branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_trap, stall_cycles, flush_count
  );

  modport slave (
    input  load_use_stall, branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_trap, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Free-running stall-cycle and redirect counters; only built when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  logic [1:0]       inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign inc = {flush_inc, stall_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (inc[gi])
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cycles = cnt_val[0];
  assign flush_count  = cnt_val[1];
endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline with data-memory watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [WAIT_W-1:0] wait_inc;
  hz_ctrl_t          ctrl;
  logic              freeze;
  logic              br_honoured;

  // Once waiting, only dmem_ready matters: the frozen MEM stage keeps its request.
  assign freeze = (state_reg == MEM_WAIT) ? !hz.dmem_ready
                                          : (hz.dmem_req && !hz.dmem_ready);

  always_comb begin
    state_next  = RUN;
    wait_next   = '0;
    wait_inc    = '0;
    ctrl        = CTRL_RUN;
    br_honoured = 1'b0;
    if (state_reg == TRAP) begin
      state_next = TRAP;
      ctrl       = CTRL_TRAP;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
      if (state_reg != MEM_WAIT)
        wait_inc = WAIT_W'(1);
      else if (wait_reg == '1)
        wait_inc = wait_reg;
      else
        wait_inc = wait_reg + WAIT_W'(1);
      wait_next  = wait_inc;
      state_next = (wait_inc >= TIMEOUT) ? TRAP : MEM_WAIT;
    end else if (hz.branch_taken) begin
      ctrl        = CTRL_BRANCH;
      state_next  = SHADOW;
      br_honoured = 1'b1;
    end else if (hz.load_use_stall && state_reg != SHADOW) begin
      // The instruction in ID after a redirect is already a NOP, so no stall there.
      ctrl = CTRL_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.if_id_en    = ctrl.if_id_en;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_en    = ctrl.id_ex_en;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.ex_mem_en   = ctrl.ex_mem_en;
  assign hz.mem_wb_en   = ctrl.mem_wb_en;
  assign hz.mem_trap    = ctrl.mem_trap;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    (!ctrl.pc_en && state_reg != TRAP),
    .flush_inc    (br_honoured),
    .stall_cycles (hz.stall_cycles),
    .flush_count  (hz.flush_count)
  );
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (watchdog shortened to 4 cycles).
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 32;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_trap}
  localparam logic [7:0] E_RUN    = 8'b1101_0110;
  localparam logic [7:0] E_STALL  = 8'b0001_1110;
  localparam logic [7:0] E_BRANCH = 8'b1111_1110;
  localparam logic [7:0] E_FREEZE = 8'b0000_0000;
  localparam logic [7:0] E_TRAP   = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  task automatic check_ctrl(input string tag);
    logic [7:0] exp_v, obs_v;
    exp_v = exp_q.pop_front();
    obs_v = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
             hz.ex_mem_en, hz.mem_wb_en, hz.mem_trap};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
    end
    $display("txn %-12s ctrl=%b expect=%b stall=%0d flush=%0d",
             tag, obs_v, exp_v, hz.stall_cycles, hz.flush_count);
  endtask

  task automatic check_cnt(input string tag);
    logic [CNT_W-1:0] want_s, want_f;
`ifdef PIPE_PERF_CNT_EN
    want_s = exp_stall;
    want_f = exp_flush;
`else
    want_s = '0;
    want_f = '0;
`endif
    checks++;
    assert (hz.stall_cycles === want_s) else begin
      failures++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, hz.stall_cycles, want_s);
    end
    checks++;
    assert (hz.flush_count === want_f) else begin
      failures++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", tag, hz.flush_count, want_f);
    end
  endtask

  task automatic step(input string tag, input logic lu, input logic br,
                      input logic req, input logic rdy, input logic [7:0] exp_v);
    @(negedge clk);
    check_cnt(tag);
    hz.load_use_stall = lu;
    hz.branch_taken   = br;
    hz.dmem_req       = req;
    hz.dmem_ready     = rdy;
    exp_q.push_back(exp_v);
    #1;
    check_ctrl(tag);
    if (!exp_v[7] && exp_v != E_TRAP) exp_stall = exp_stall + 1'b1;
    if (exp_v == E_BRANCH) exp_flush = exp_flush + 1'b1;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    hz.load_use_stall = 1'b0;
    hz.branch_taken   = 1'b0;
    hz.dmem_req       = 1'b0;
    hz.dmem_ready     = 1'b0;
    rst_n = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    exp_q.push_back(E_RUN);
    #1;
    check_ctrl(tag);
    check_cnt(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    hz.load_use_stall = 1'b0;
    hz.branch_taken   = 1'b0;
    hz.dmem_req       = 1'b0;
    hz.dmem_ready     = 1'b0;
    apply_reset("reset_init");
    step("idle", 0, 0, 0, 0, E_RUN);

    // load-use stall for one cycle, then release
    step("lu_stall", 1, 0, 0, 0, E_STALL);
    step("lu_release", 0, 0, 0, 0, E_RUN);

    // branch beats load-use; load-use ignored in the shadow cycle
    step("br_and_lu", 1, 1, 0, 0, E_BRANCH);
    step("shadow_lu", 1, 0, 0, 0, E_RUN);
    step("lu_after", 1, 0, 0, 0, E_STALL);
    step("idle2", 0, 0, 0, 0, E_RUN);
    step("br_a", 0, 1, 0, 0, E_BRANCH);
    step("shadow_br", 0, 1, 0, 0, E_BRANCH);
    step("idle3", 0, 0, 0, 0, E_RUN);

    // three-cycle memory wait, then completion
    step("mwait1", 0, 0, 1, 0, E_FREEZE);
    step("mwait2", 0, 0, 1, 0, E_FREEZE);
    step("mwait3", 0, 0, 1, 0, E_FREEZE);
    step("mready", 0, 0, 1, 1, E_RUN);
    step("idle4", 0, 0, 0, 0, E_RUN);

    // memory wait outranks branch; branch honoured on the ready cycle
    step("mw_vs_br", 0, 1, 1, 0, E_FREEZE);
    step("mrdy_br", 0, 1, 1, 1, E_BRANCH);
    step("shadow_lu2", 1, 0, 0, 0, E_RUN);
    step("mw_vs_lu", 1, 0, 1, 0, E_FREEZE);
    step("mrdy_lu", 1, 0, 0, 1, E_STALL);
    step("idle5", 0, 0, 0, 0, E_RUN);

    // reset in the middle of a wait, then a fresh wait below the timeout
    step("rmw1", 0, 0, 1, 0, E_FREEZE);
    step("rmw2", 0, 0, 1, 0, E_FREEZE);
    apply_reset("reset_midwait");
    step("post_rst", 0, 0, 0, 0, E_RUN);
    step("fw1", 0, 0, 1, 0, E_FREEZE);
    step("fw2", 0, 0, 1, 0, E_FREEZE);
    step("fw3", 0, 0, 1, 0, E_FREEZE);
    step("fw_ready", 0, 0, 1, 1, E_RUN);

    // watchdog: four wait cycles then sticky trap
    step("to1", 0, 0, 1, 0, E_FREEZE);
    step("to2", 0, 0, 1, 0, E_FREEZE);
    step("to3", 0, 0, 1, 0, E_FREEZE);
    step("to4", 0, 0, 1, 0, E_FREEZE);
    step("trap_rdy", 0, 1, 1, 1, E_TRAP);
    step("trap_idle", 0, 0, 0, 0, E_TRAP);
    step("trap_lu", 1, 0, 0, 0, E_TRAP);
    apply_reset("reset_trap");
    step("after_trap", 0, 0, 0, 0, E_RUN);
    step("lu_final", 1, 0, 0, 0, E_STALL);
    step("end", 0, 0, 0, 0, E_RUN);
    @(negedge clk);
    check_cnt("final_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
